// File: rtl/rx_link_sync_fsm.sv
// rx_link_sync_fsm: JESD204B receive-side link synchronisation for one lane.
// Sits behind the 8b/10b decoder. It runs code group sync, drives SYNC~,
// checks the ILA sequence and then tags user-data octets for the deframer.
// Optional feature macro: ILA_CAPTURE_EN. When it is defined, the 14
// configuration octets following /Q/ in ILA multiframe 2 are captured and
// exposed on o_ila_cfg / o_ila_cfg_vld.
module rx_link_sync_fsm #(
    parameter int K_CNT_MIN   = 4,
    parameter int ILA_MF      = 4,
    parameter int ERR_THRESH  = 3,
    parameter int ILA_TIMEOUT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    input  logic [7:0]   i_data,
    input  logic         i_charisk,
    input  logic         i_code_err,
    input  logic         i_lmfc_clk,
    output logic         o_sync_n,
    output logic         o_cgs_done,
    output logic         o_ila_done,
    output logic         o_data_valid,
    output logic [7:0]   o_data,
    output logic         o_ila_err,
    output logic [2:0]   o_state
`ifdef ILA_CAPTURE_EN
    ,
    output logic [111:0] o_ila_cfg,
    output logic         o_ila_cfg_vld
`endif
);

    localparam logic [2:0] CS_INIT  = 3'd0;
    localparam logic [2:0] CS_CHECK = 3'd1;
    localparam logic [2:0] ILA_WAIT = 3'd2;
    localparam logic [2:0] ILA      = 3'd3;
    localparam logic [2:0] DATA     = 3'd4;

    localparam logic [7:0] OCT_K = 8'hBC;
    localparam logic [7:0] OCT_R = 8'h1C;
    localparam logic [7:0] OCT_A = 8'h7C;

    localparam int KW = $clog2(K_CNT_MIN + 1);
    localparam int MW = $clog2(ILA_MF + 1);
    localparam int EW = $clog2(ERR_THRESH + 1);
    localparam int TW = $clog2(ILA_TIMEOUT + 1);
    // clean octets in a row that wipe the error count
    localparam int CLEAN_RUN = 4;
    localparam int CW = $clog2(CLEAN_RUN + 1);

    logic [2:0]    state, state_nxt;
    logic [KW-1:0] k_cnt, k_nxt;
    logic [MW-1:0] mf_cnt, mf_nxt;
    logic [EW-1:0] err_cnt, err_nxt;
    logic [CW-1:0] clean_cnt, clean_nxt;
    logic [TW-1:0] to_cnt, to_nxt;
    logic          r_pend, r_pend_nxt;   // /A/ seen, next octet must be /R/
    logic          sync_n_nxt, ila_done_nxt, ila_err_nxt, dv_nxt;
    logic          viol, thresh, to_init;

    logic is_k, is_r, is_a;
    assign is_k = i_valid && i_charisk && (i_data == OCT_K);
    assign is_r = i_valid && i_charisk && (i_data == OCT_R);
    assign is_a = i_valid && i_charisk && (i_data == OCT_A);

    assign o_state = state;

    // next-state, counter and output decode; resync overrides everything
    always_comb begin
        state_nxt    = state;
        k_nxt        = k_cnt;
        mf_nxt       = mf_cnt;
        err_nxt      = err_cnt;
        clean_nxt    = clean_cnt;
        to_nxt       = to_cnt;
        r_pend_nxt   = r_pend;
        sync_n_nxt   = o_sync_n;
        ila_done_nxt = o_ila_done;
        ila_err_nxt  = 1'b0;
        viol         = 1'b0;
        thresh       = 1'b0;
        to_init      = 1'b0;

        case (state)
            CS_INIT: begin
                if (i_valid) begin
                    if (is_k && !i_code_err) begin
                        if (k_cnt == KW'(K_CNT_MIN - 1)) begin
                            state_nxt = CS_CHECK;
                            k_nxt     = '0;
                        end else begin
                            k_nxt = k_cnt + 1'b1;
                        end
                    end else begin
                        k_nxt = '0;
                    end
                end
            end
            CS_CHECK: begin
                if (i_lmfc_clk) begin
                    state_nxt  = ILA_WAIT;
                    sync_n_nxt = 1'b1;
                end
            end
            ILA_WAIT: begin
                // an octet decision outranks a timeout on the same cycle
                if (i_valid && !is_k) begin
                    if (is_r) begin
                        state_nxt  = ILA;
                        mf_nxt     = '0;
                        r_pend_nxt = 1'b0;
                    end else begin
                        viol = 1'b1;
                    end
                end else if (i_lmfc_clk) begin
                    if (to_cnt == TW'(ILA_TIMEOUT - 1))
                        viol = 1'b1;
                    else
                        to_nxt = to_cnt + 1'b1;
                end
            end
            ILA: begin
                if (i_valid) begin
                    if (r_pend) begin
                        if (is_r)
                            r_pend_nxt = 1'b0;
                        else
                            viol = 1'b1;
                    end else if (is_a) begin
                        mf_nxt = mf_cnt + 1'b1;
                        if (mf_cnt == MW'(ILA_MF - 1)) begin
                            state_nxt    = DATA;
                            ila_done_nxt = 1'b1;
                        end else begin
                            r_pend_nxt = 1'b1;
                        end
                    end
                end
            end
            DATA: begin
            end
            default: begin
                to_init = 1'b1;
            end
        endcase

        // code error tracking once CGS has passed
        if (state != CS_INIT && i_valid) begin
            if (i_code_err) begin
                clean_nxt = '0;
                if (err_cnt != EW'(ERR_THRESH))
                    err_nxt = err_cnt + 1'b1;
                if (err_nxt == EW'(ERR_THRESH))
                    thresh = 1'b1;
            end else if (clean_cnt == CW'(CLEAN_RUN - 1)) begin
                clean_nxt = '0;
                err_nxt   = '0;
            end else begin
                clean_nxt = clean_cnt + 1'b1;
            end
        end

        if (viol && !thresh)
            ila_err_nxt = 1'b1;
        if (viol || thresh)
            to_init = 1'b1;

        if (to_init) begin
            state_nxt    = CS_INIT;
            k_nxt        = '0;
            mf_nxt       = '0;
            err_nxt      = '0;
            clean_nxt    = '0;
            to_nxt       = '0;
            r_pend_nxt   = 1'b0;
            sync_n_nxt   = 1'b0;
            ila_done_nxt = 1'b0;
        end

        // the /A/ that closes the ILA is not data, so only DATA->DATA flags
        dv_nxt = (state == DATA) && !to_init && i_valid;
    end

    // state, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= CS_INIT;
            k_cnt        <= '0;
            mf_cnt       <= '0;
            err_cnt      <= '0;
            clean_cnt    <= '0;
            to_cnt       <= '0;
            r_pend       <= 1'b0;
            o_sync_n     <= 1'b0;
            o_cgs_done   <= 1'b0;
            o_ila_done   <= 1'b0;
            o_data_valid <= 1'b0;
            o_data       <= 8'h00;
            o_ila_err    <= 1'b0;
        end else begin
            state        <= state_nxt;
            k_cnt        <= k_nxt;
            mf_cnt       <= mf_nxt;
            err_cnt      <= err_nxt;
            clean_cnt    <= clean_nxt;
            to_cnt       <= to_nxt;
            r_pend       <= r_pend_nxt;
            o_sync_n     <= sync_n_nxt;
            o_cgs_done   <= (state_nxt != CS_INIT);
            o_ila_done   <= ila_done_nxt;
            o_data_valid <= dv_nxt;
            o_data       <= i_data;
            o_ila_err    <= ila_err_nxt;
        end
    end

`ifdef ILA_CAPTURE_EN
    localparam logic [7:0] OCT_Q = 8'h9C;

    logic       is_q;
    logic       cap_on;
    logic [3:0] cap_idx;
    assign is_q = i_valid && i_charisk && (i_data == OCT_Q);

    // capture the 14 config octets after /Q/ in the second multiframe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_on        <= 1'b0;
            cap_idx       <= 4'd0;
            o_ila_cfg     <= '0;
            o_ila_cfg_vld <= 1'b0;
        end else if (to_init) begin
            cap_on        <= 1'b0;
            cap_idx       <= 4'd0;
            o_ila_cfg     <= '0;
            o_ila_cfg_vld <= 1'b0;
        end else begin
            o_ila_cfg_vld <= ila_done_nxt;
            if (state == ILA && i_valid) begin
                if (cap_on) begin
                    o_ila_cfg[{cap_idx, 3'b000} +: 8] <= i_data;
                    cap_idx <= cap_idx + 4'd1;
                    if (cap_idx == 4'd13)
                        cap_on <= 1'b0;
                end else if (is_q && !r_pend && mf_cnt == MW'(1) && cap_idx == 4'd0) begin
                    cap_on <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rx_link_sync_fsm.sv
// Directed bench for rx_link_sync_fsm: CGS, SYNC~ release, ILA acceptance,
// ILA violations/timeout, error-threshold resync and asynchronous reset.
module tb_rx_link_sync_fsm;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid, i_charisk, i_code_err, i_lmfc_clk;
    logic [7:0]   i_data;
    logic         o_sync_n, o_cgs_done, o_ila_done, o_data_valid, o_ila_err;
    logic [7:0]   o_data;
    logic [2:0]   o_state;
`ifdef ILA_CAPTURE_EN
    logic [111:0] o_ila_cfg;
    logic         o_ila_cfg_vld;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rx_link_sync_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .i_charisk    (i_charisk),
        .i_code_err   (i_code_err),
        .i_lmfc_clk   (i_lmfc_clk),
        .o_sync_n     (o_sync_n),
        .o_cgs_done   (o_cgs_done),
        .o_ila_done   (o_ila_done),
        .o_data_valid (o_data_valid),
        .o_data       (o_data),
        .o_ila_err    (o_ila_err),
        .o_state      (o_state)
`ifdef ILA_CAPTURE_EN
        ,
        .o_ila_cfg    (o_ila_cfg),
        .o_ila_cfg_vld(o_ila_cfg_vld)
`endif
    );

    task automatic chk(input string tag, input logic [111:0] got, input logic [111:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // present one octet for one clock, return 1 time unit after the edge
    task automatic step(input logic v, input logic [7:0] d, input logic k,
                        input logic e, input logic l);
        i_valid = v; i_data = d; i_charisk = k; i_code_err = e; i_lmfc_clk = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_k();
        step(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0);
    endtask

    // CGS plus SYNC~ release: ends in ILA_WAIT
    task automatic to_ila_wait();
        for (int i = 0; i < 4; i++) send_k();
        step(1'b1, 8'hBC, 1'b1, 1'b0, 1'b1);
    endtask

    // one ILA multiframe; mf 2 carries /Q/ and config octets 01..0E
    task automatic ila_mf(input int mf);
        step(1'b1, 8'h1C, 1'b1, 1'b0, 1'b0);
        if (mf == 2) begin
            step(1'b1, 8'h9C, 1'b1, 1'b0, 1'b0);
            for (int i = 1; i <= 14; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        end else begin
            step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
            step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 8'h7C, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic to_data();
        to_ila_wait();
        for (int m = 1; m <= 4; m++) ila_mf(m);
    endtask

    task automatic err_oct();
        step(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic clean_oct(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [111:0] cfg_exp;
        rst = 1'b1;
        i_valid = 0; i_data = 0; i_charisk = 0; i_code_err = 0; i_lmfc_clk = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sync_n", o_sync_n, 0);
        chk("rst_state", o_state, 0);
        chk("rst_cgs", o_cgs_done, 0);
        chk("rst_ila_done", o_ila_done, 0);
        chk("rst_dv", o_data_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_ila_err", o_ila_err, 0);
        rst = 1'b0;

        // interrupted /K/ run restarts the count
        for (int i = 0; i < 3; i++) send_k();
        chk("cgs_3k_state", o_state, 0);
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_k();
        chk("cgs_restart_3k_state", o_state, 0);
        send_k();
        chk("cgs_4k_state", o_state, 1);
        chk("cgs_4k_done", o_cgs_done, 1);
        chk("cgs_4k_sync_n", o_sync_n, 0);

        // LMFC pulse 10 cycles later releases SYNC~
        for (int i = 0; i < 9; i++) send_k();
        chk("check_hold_sync_n", o_sync_n, 0);
        chk("check_hold_state", o_state, 1);
        step(1'b1, 8'hBC, 1'b1, 1'b0, 1'b1);
        chk("lmfc_sync_n", o_sync_n, 1);
        chk("lmfc_state", o_state, 2);

        // full ILA then one user octet
        ila_mf(1);
        chk("ila_state", o_state, 3);
        for (int m = 2; m <= 4; m++) ila_mf(m);
        chk("ila_done", o_ila_done, 1);
        chk("ila_state_data", o_state, 4);
        chk("ila_last_a_not_data", o_data_valid, 0);
`ifdef ILA_CAPTURE_EN
        for (int i = 0; i < 14; i++) cfg_exp[i*8 +: 8] = 8'(i + 1);
        chk("cfg_vld", o_ila_cfg_vld, 1);
        chk("cfg_value", o_ila_cfg, cfg_exp);
`else
        cfg_exp = '0;
`endif
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        chk("data_valid", o_data_valid, 1);
        chk("data_value", o_data, 8'h5A);
        idle();
        chk("data_idle_dv", o_data_valid, 0);

        // errors with short clean gaps force resync
        err_oct(); clean_oct(3); err_oct(); clean_oct(3);
        chk("err2_still_data", o_state, 4);
        err_oct();
        idle();
        chk("err_thresh_state", o_state, 0);
        chk("err_thresh_sync_n", o_sync_n, 0);
        chk("err_thresh_ila_done", o_ila_done, 0);
        chk("err_thresh_cgs", o_cgs_done, 0);
`ifdef ILA_CAPTURE_EN
        chk("err_cfg_vld_clr", o_ila_cfg_vld, 0);
`endif

        // four clean octets between errors keep the link up
        to_data();
        chk("relink_state", o_state, 4);
        err_oct(); clean_oct(4); err_oct(); clean_oct(4); err_oct(); clean_oct(1);
        chk("err_spaced_state", o_state, 4);
        chk("err_spaced_ila_done", o_ila_done, 1);
        chk("err_spaced_sync_n", o_sync_n, 1);

        // asynchronous reset mid-operation
        #2 rst = 1'b1;
        #1;
        chk("async_rst_state", o_state, 0);
        chk("async_rst_ila_done", o_ila_done, 0);
        chk("async_rst_sync_n", o_sync_n, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // ILA_WAIT: non-/R/ octet is a violation
        to_ila_wait();
        chk("wait_state", o_state, 2);
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("wait_viol_err", o_ila_err, 1);
        chk("wait_viol_state", o_state, 0);
        chk("wait_viol_sync_n", o_sync_n, 0);
        idle();
        chk("wait_viol_pulse_end", o_ila_err, 0);

        // ILA_WAIT: timeout after 8 LMFC pulses without /R/
        to_ila_wait();
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("timeout_7_state", o_state, 2);
        chk("timeout_7_err", o_ila_err, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("timeout_8_state", o_state, 0);
        chk("timeout_8_err", o_ila_err, 1);

        // ILA: missing /R/ after /A/
        to_ila_wait();
        ila_mf(1);
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        chk("ila_no_r_err", o_ila_err, 1);
        chk("ila_no_r_state", o_state, 0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
